// File: rtl/adc_serial_emulator_if.sv
// ============================================================================
//  Module   : adc_serial_emulator_if
//  Purpose  : ADC pin bundle (CNV/SCK/SDO) plus control and status for the emulator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface adc_serial_emulator_if #(
  parameter int ADC_WIDTH = 16,
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16
);
  logic [NUM_CH*ADC_WIDTH-1:0] fake_data;
  logic                        cnv;
  logic                        sck;
  logic                        chain_mode;
  logic                        busy_ind_en;
  logic                        err_clr;
  logic [NUM_CH-1:0]           sdo;
  logic                        busy;
  logic [CNT_WIDTH-1:0]        conv_count;
  logic                        conv_err;
  logic                        sck_err;

  modport master (
    output fake_data, cnv, sck, chain_mode, busy_ind_en, err_clr,
    input  sdo, busy, conv_count, conv_err, sck_err
  );

  modport slave (
    input  fake_data, cnv, sck, chain_mode, busy_ind_en, err_clr,
    output sdo, busy, conv_count, conv_err, sck_err
  );
endinterface

`default_nettype wire

// File: rtl/adc_serial_emulator.sv
// ============================================================================
//  Module   : adc_serial_emulator
//  Purpose  : Clocked multi-channel emulation of a CNV/SCK/SDO SAR ADC readout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_serial_emulator #(
  parameter int ADC_WIDTH     = 16,
  parameter int NUM_CH        = 4,
  parameter int T_CONV_CYCLES = 29,
  parameter int CNT_WIDTH     = 16
) (
  input wire                   clk,
  input wire                   rst_n,
  adc_serial_emulator_if.slave bus
);

  localparam int C_CHAIN_BITS = NUM_CH * ADC_WIDTH;
  localparam int C_BIT_W      = $clog2(C_CHAIN_BITS + 1);
  localparam int C_TMR_W      = (T_CONV_CYCLES > 1) ? $clog2(T_CONV_CYCLES) : 1;
  localparam logic [C_TMR_W-1:0] C_TMR_LOAD = C_TMR_W'(T_CONV_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_CONVERT      = 3'd1,
    S_WAIT_CNV_LOW = 3'd2,
    S_READY        = 3'd3,
    S_READOUT      = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [2:0]              r_cnv_sync;
  logic [2:0]              r_sck_sync;
  logic [C_TMR_W-1:0]      r_tmr;
  logic [C_BIT_W-1:0]      r_bit_cnt;
  logic [ADC_WIDTH-1:0]    r_data [NUM_CH];
  logic [NUM_CH-1:0]       r_sdo;
  logic                    r_busy;
  logic [CNT_WIDTH-1:0]    r_conv_count;
  logic                    r_conv_err;
  logic                    r_sck_err;
  logic                    r_chain;
  logic                    r_busy_en;

  logic                    w_cnv_rise;
  logic                    w_cnv_fall;
  logic                    w_sck_fall;
  logic                    w_last_bit;
  logic                    w_load;
  logic                    w_conv_done;
  logic                    w_set_ready;
  logic                    w_shift;
  logic                    w_finish;
  logic                    w_conv_err_evt;
  logic                    w_sck_err_evt;
  logic [NUM_CH-1:0]       w_fill;
  logic [NUM_CH-1:0]       w_shift_sdo;
  logic [NUM_CH-1:0]       w_ready_sdo;

  // Stage [1] is the synchronised level, stage [2] the previous level for edge detection.
  assign w_cnv_rise = r_cnv_sync[1] & ~r_cnv_sync[2];
  assign w_cnv_fall = ~r_cnv_sync[1] & r_cnv_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];

  assign w_last_bit  = (r_bit_cnt == (r_chain ? C_BIT_W'(C_CHAIN_BITS) : C_BIT_W'(ADC_WIDTH)));
  assign w_ready_sdo = r_busy_en ? (r_chain ? ~NUM_CH'(1) : '0) : '1;

  // In chain mode each channel's register refills from the next channel's MSB, so
  // sdo[0] walks ch0, ch1, ... as one long word.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    if (gi < NUM_CH - 1) begin : g_link
      assign w_fill[gi] = r_chain & r_data[gi+1][ADC_WIDTH-1];
    end else begin : g_tail
      assign w_fill[gi] = 1'b0;
    end
    if (gi == 0) begin : g_head
      assign w_shift_sdo[gi] = r_data[gi][ADC_WIDTH-1];
    end else begin : g_rest
      assign w_shift_sdo[gi] = r_chain | r_data[gi][ADC_WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_load         = 1'b0;
    w_conv_done    = 1'b0;
    w_set_ready    = 1'b0;
    w_shift        = 1'b0;
    w_finish       = 1'b0;
    w_conv_err_evt = 1'b0;
    w_sck_err_evt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cnv_rise) begin
          w_load       = 1'b1;
          w_state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        w_conv_err_evt = w_cnv_rise;
        w_sck_err_evt  = w_sck_fall;
        if (r_tmr == '0) begin
          w_conv_done = 1'b1;
          if (r_cnv_sync[1]) begin
            w_state_next = S_WAIT_CNV_LOW;
          end else begin
            w_set_ready  = 1'b1;
            w_state_next = S_READY;
          end
        end
      end
      S_WAIT_CNV_LOW: begin
        if (w_cnv_fall) begin
          w_set_ready  = 1'b1;
          w_state_next = S_READY;
        end
      end
      S_READY: begin
        if (w_cnv_rise) begin
          w_conv_err_evt = 1'b1;
          w_load         = 1'b1;
          w_state_next   = S_CONVERT;
        end else if (w_sck_fall) begin
          w_shift      = 1'b1;
          w_state_next = S_READOUT;
        end
      end
      S_READOUT: begin
        if (w_cnv_rise) begin
          w_conv_err_evt = 1'b1;
          w_load         = 1'b1;
          w_state_next   = S_CONVERT;
        end else if (w_sck_fall) begin
          if (w_last_bit) begin
            w_finish     = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnv_sync   <= '0;
      r_sck_sync   <= '0;
      r_tmr        <= '0;
      r_bit_cnt    <= '0;
      r_sdo        <= '1;
      r_busy       <= 1'b0;
      r_conv_count <= '0;
      r_conv_err   <= 1'b0;
      r_sck_err    <= 1'b0;
      r_chain      <= 1'b0;
      r_busy_en    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      r_cnv_sync <= {r_cnv_sync[1:0], bus.cnv};
      r_sck_sync <= {r_sck_sync[1:0], bus.sck};
      r_conv_err <= (r_conv_err & ~bus.err_clr) | w_conv_err_evt;
      r_sck_err  <= (r_sck_err & ~bus.err_clr) | w_sck_err_evt;

      if (w_load) begin
        r_tmr     <= C_TMR_LOAD;
        r_busy    <= 1'b1;
        r_sdo     <= '1;
        r_bit_cnt <= '0;
        r_chain   <= bus.chain_mode;
        r_busy_en <= bus.busy_ind_en;
        for (int k = 0; k < NUM_CH; k++) begin
          r_data[k] <= bus.fake_data[k*ADC_WIDTH +: ADC_WIDTH];
        end
      end else begin
        if (r_state == S_CONVERT && r_tmr != '0) begin
          r_tmr <= r_tmr - 1'b1;
        end
        if (w_conv_done) begin
          r_busy       <= 1'b0;
          r_conv_count <= r_conv_count + 1'b1;
        end
        if (w_set_ready) begin
          r_sdo <= w_ready_sdo;
        end
        if (w_shift) begin
          r_sdo     <= w_shift_sdo;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          for (int k = 0; k < NUM_CH; k++) begin
            r_data[k] <= {r_data[k][ADC_WIDTH-2:0], w_fill[k]};
          end
        end
        if (w_finish) begin
          r_sdo     <= '1;
          r_bit_cnt <= '0;
        end
      end
    end
  end

  assign bus.sdo        = r_sdo;
  assign bus.busy       = r_busy;
  assign bus.conv_count = r_conv_count;
  assign bus.conv_err   = r_conv_err;
  assign bus.sck_err    = r_sck_err;

endmodule

`default_nettype wire

// File: tb/tb_adc_serial_emulator.sv
// ============================================================================
//  Module   : tb_adc_serial_emulator
//  Purpose  : Randomised self-checking bench for adc_serial_emulator against a word-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adc_serial_emulator;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int T  = 29;
  localparam int CW = 4;
  localparam logic [N-1:0] C_ALL1 = '1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_serial_emulator_if #(.ADC_WIDTH(W), .NUM_CH(N), .CNT_WIDTH(CW)) bus ();

  adc_serial_emulator #(
    .ADC_WIDTH    (W),
    .NUM_CH       (N),
    .T_CONV_CYCLES(T),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int             n_total = 0;
  int             n_bad   = 0;
  logic [N*W-1:0] m_snap;
  bit             m_chain;
  bit             m_ben;
  int             m_count;
  bit             m_conv_err;
  bit             m_sck_err;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected sdo after the (i+1)-th sck fall: the snapshot words, MSB first.
  function automatic logic [N-1:0] exp_sdo(input int i);
    logic [N-1:0] v;
    v = C_ALL1;
    if (m_chain) begin
      v[0] = m_snap[(i / W) * W + (W - 1 - (i % W))];
    end else begin
      for (int k = 0; k < N; k++) v[k] = m_snap[k*W + W - 1 - i];
    end
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] v;
    v = C_ALL1;
    if (m_ben) begin
      if (m_chain) v[0] = 1'b0;
      else         v    = '0;
    end
    return v;
  endfunction

  task automatic start_conv(input logic [N*W-1:0] data, input bit chain, input bit ben,
                            input int cnv_hi, input bit change, input bit sck_viol, input bit abort);
    int t;
    int b_start;
    int b_len;
    logic [63:0] r64;
    bus.fake_data   = data;
    bus.chain_mode  = chain;
    bus.busy_ind_en = ben;
    m_snap  = data;
    m_chain = chain;
    m_ben   = ben;
    if (abort)    m_conv_err = 1'b1;
    if (sck_viol) m_sck_err  = 1'b1;
    bus.cnv = 1'b1;
    t = 0;
    b_start = -1;
    b_len = 0;
    while (t < 200) begin
      @(negedge clk);
      t++;
      if (bus.busy) begin
        if (b_start < 0) b_start = t;
        b_len++;
      end
      if (t == 5 && change) begin
        r64 = {$urandom(), $urandom()};
        bus.fake_data = r64[N*W-1:0];
      end
      if (sck_viol && t == 10) bus.sck = 1'b1;
      if (sck_viol && t == 12) bus.sck = 1'b0;
      if (t == 10) check_value("sdo_convert", 64'(bus.sdo), 64'(C_ALL1));
      if (cnv_hi > 40) begin
        if (t == cnv_hi - 1) check_value("sdo_wait_cnv_low", 64'(bus.sdo), 64'(C_ALL1));
        if (t == cnv_hi + 2) check_value("sdo_before_ind", 64'(bus.sdo), 64'(C_ALL1));
      end
      if (t == cnv_hi) bus.cnv = 1'b0;
      if (t >= cnv_hi + 3 && t >= T + 6) break;
    end
    m_count = (m_count + 1) % (1 << CW);
    check_value("busy_start", 64'(b_start), 64'(3));
    check_value("busy_len", 64'(b_len), 64'(T));
    check_value("sdo_ready", 64'(bus.sdo), 64'(exp_ready()));
    check_value("conv_count", 64'(bus.conv_count), 64'(m_count));
    check_value("conv_err", 64'(bus.conv_err), 64'(m_conv_err));
    check_value("sck_err", 64'(bus.sck_err), 64'(m_sck_err));
  endtask

  task automatic sck_pulse();
    bus.sck = 1'b1;
    tick(4);
    bus.sck = 1'b0;
    tick(4);
  endtask

  task automatic readout(input int nbits);
    int len;
    len = m_chain ? N * W : W;
    for (int i = 0; i < nbits; i++) begin
      sck_pulse();
      check_value($sformatf("sdo_bit%0d", i), 64'(bus.sdo), 64'(exp_sdo(i)));
    end
    if (nbits == len) begin
      sck_pulse();
      check_value("sdo_end", 64'(bus.sdo), 64'(C_ALL1));
    end
  endtask

  task automatic clear_errors();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    m_conv_err = 1'b0;
    m_sck_err  = 1'b0;
    check_value("conv_err_clr", 64'(bus.conv_err), 64'(0));
    check_value("sck_err_clr", 64'(bus.sck_err), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r64;
    bus.fake_data   = '0;
    bus.cnv         = 1'b0;
    bus.sck         = 1'b0;
    bus.chain_mode  = 1'b0;
    bus.busy_ind_en = 1'b0;
    bus.err_clr     = 1'b0;
    m_count    = 0;
    m_conv_err = 1'b0;
    m_sck_err  = 1'b0;
    tick(3);
    check_value("rst_sdo", 64'(bus.sdo), 64'(C_ALL1));
    check_value("rst_busy", 64'(bus.busy), 64'(0));
    check_value("rst_count", 64'(bus.conv_count), 64'(0));
    rst_n = 1'b1;
    tick(2);

    // Basic read: ch0=A5C3, ch3=0001, busy indicator on
    start_conv({16'h0001, 16'h7E18, 16'h3C5A, 16'hA5C3}, 1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0);
    readout(W);
    sck_pulse();
    check_value("sdo_after_idle_sck", 64'(bus.sdo), 64'(C_ALL1));

    // Long CNV, indicator follows the cnv fall
    start_conv({16'h1234, 16'h8001, 16'hFFFF, 16'h0F0F}, 1'b0, 1'b1, 50, 1'b0, 1'b0, 1'b0);
    readout(W);

    // Daisy chain
    start_conv({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b0);
    readout(N * W);

    // Snapshot held while fake_data moves
    start_conv({16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, 1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b0);
    readout(W);

    // Violations: sck during convert, then abort at bit 7 with fresh data
    start_conv({16'h0101, 16'h0202, 16'h0303, 16'h0404}, 1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b0);
    readout(7);
    start_conv({16'hABCD, 16'h5678, 16'h9ABC, 16'hEF01}, 1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b1);
    readout(W);
    clear_errors();

    // Asynchronous reset mid-readout
    start_conv({16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000}, 1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b0);
    readout(5);
    rst_n = 1'b0;
    #1;
    check_value("arst_sdo", 64'(bus.sdo), 64'(C_ALL1));
    check_value("arst_busy", 64'(bus.busy), 64'(0));
    check_value("arst_count", 64'(bus.conv_count), 64'(0));
    check_value("arst_conv_err", 64'(bus.conv_err), 64'(0));
    check_value("arst_sck_err", 64'(bus.sck_err), 64'(0));
    m_count    = 0;
    m_conv_err = 1'b0;
    m_sck_err  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Randomised conversions; more than 2^CW of them so conv_count wraps
    for (int it = 0; it < 18; it++) begin
      bit ch;
      r64 = {$urandom(), $urandom()};
      ch  = 1'($urandom_range(0, 1));
      start_conv(r64[N*W-1:0], ch, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? 50 : 20, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      readout(ch ? N * W : W);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
